// File: rtl/freq_gate_counter.sv
// freq_gate_counter
//   Measurement front end of the frequency counter. Synchronises sig_in,
//   counts its rising edges over a gate window of GATE_CYCLES clocks and
//   latches the count, saturated at MAX_COUNT, once per window.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   sig_in in   asynchronous signal under measurement
//   hold   in   1 = keep freq/over frozen at the window boundary
//   freq   out  [15:0] latched edge count of the last completed window
//   over   out  last latched window counted more than MAX_COUNT edges
//   valid  out  one-cycle pulse when freq/over have just been updated
module freq_gate_counter #(
  parameter int unsigned GATE_CYCLES = 100000000,
  parameter int unsigned MAX_COUNT   = 9999,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sig_in,
  input  logic        hold,
  output logic [15:0] freq,
  output logic        over,
  output logic        valid
);

  localparam int unsigned TMR_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  // Holds up to ceil(GATE_CYCLES/2) edges so the count cannot wrap in a window.
  localparam int unsigned CNT_W = $clog2(GATE_CYCLES / 2 + 2);
  localparam int unsigned FL_W  = $clog2(SYNC_STAGES + 1);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(SYNC_STAGES);

  typedef enum logic {
    FLUSH,
    GATE
  } state_t;

  state_t                   state_q,     state_d;
  logic [SYNC_STAGES-1:0]   sync_q,      sync_d;
  logic                     prev_q,      prev_d;
  logic [FL_W-1:0]          flush_cnt_q, flush_cnt_d;
  logic [TMR_W-1:0]         timer_q,     timer_d;
  logic [CNT_W-1:0]         edge_cnt_q,  edge_cnt_d;
  logic [15:0]              freq_q,      freq_d;
  logic                     over_q,      over_d;
  logic                     valid_q,     valid_d;

  logic                     s;
  logic                     edge_det;
  logic [CNT_W-1:0]         total;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], sig_in};
    prev_d      = s;
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    timer_d     = timer_q;
    edge_cnt_d  = edge_cnt_q;
    freq_d      = freq_q;
    over_d      = over_q;
    valid_d     = 1'b0;

    edge_det = s & ~prev_q;
    // An edge seen in the terminal cycle belongs to the closing window.
    total    = edge_cnt_q + CNT_W'(edge_det);

    case (state_q)
      FLUSH: begin
        // Let the sync chain and prev settle so a high sig_in at reset
        // release is not mistaken for a rising edge.
        timer_d    = '0;
        edge_cnt_d = '0;
        if (flush_cnt_q == FL_LAST) begin
          state_d = GATE;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      GATE: begin
        if (timer_q == TMR_LAST) begin
          timer_d    = '0;
          edge_cnt_d = '0;
          if (!hold) begin
            if (32'(total) > MAX_COUNT) begin
              freq_d = 16'(MAX_COUNT);
              over_d = 1'b1;
            end else begin
              freq_d = 16'(total);
              over_d = 1'b0;
            end
            valid_d = 1'b1;
          end
        end else begin
          timer_d    = timer_q + 1'b1;
          edge_cnt_d = total;
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FLUSH;
      sync_q      <= '0;
      prev_q      <= 1'b0;
      flush_cnt_q <= '0;
      timer_q     <= '0;
      edge_cnt_q  <= '0;
      freq_q      <= '0;
      over_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      flush_cnt_q <= flush_cnt_d;
      timer_q     <= timer_d;
      edge_cnt_q  <= edge_cnt_d;
      freq_q      <= freq_d;
      over_q      <= over_d;
      valid_q     <= valid_d;
    end
  end

  assign freq  = freq_q;
  assign over  = over_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
module tb_freq_gate_counter;

  localparam int GC = 100;
  localparam int MC = 20;
  localparam int SS = 2;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        sig_in = 1'b0;
  logic        hold   = 1'b0;
  logic [15:0] freq;
  logic        over;
  logic        valid;

  always #5 clk = ~clk;

  freq_gate_counter #(
    .GATE_CYCLES (GC),
    .MAX_COUNT   (MC),
    .SYNC_STAGES (SS)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .hold   (hold),
    .freq   (freq),
    .over   (over),
    .valid  (valid)
  );

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  // Reference model: history of sig_in as sampled at each clk edge since
  // reset release; an edge reaches the counter SS+1 clocks after the pin.
  bit          x[$];
  int          n;
  int          cnt;
  logic [31:0] exp_freq;
  logic [31:0] exp_over;
  logic [31:0] exp_valid;
  int          last_valid;
  bit          term_last;

  int mode;       // 0 level, 1 square, 2 random, 3 step at t_step
  bit level;
  int period;
  int t_step;
  bit rand_hold;

  function automatic logic gen(int k);
    case (mode)
      0:       return level;
      1:       return (k % period) < (period / 2);
      2:       return 1'($urandom_range(0, 1));
      default: return k >= t_step;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic model_reset();
    n = 0;
    x.delete();
    x.push_back(1'b0);
    cnt        = 0;
    exp_freq   = 0;
    exp_over   = 0;
    exp_valid  = 0;
    last_valid = -1;
    term_last  = 0;
  endtask

  task automatic step();
    int p;
    sig_in = gen(n + 1);
    if (rand_hold) hold = 1'($urandom_range(0, 1));
    @(posedge clk);
    n++;
    x.push_back(sig_in);
    exp_valid = 0;
    term_last = 0;
    if (n >= SS + 2) begin
      if (x[n-SS] && !x[n-SS-1]) cnt++;
      p = (n - (SS + 2)) % GC;
      if (p == GC - 1) begin
        term_last = 1;
        if (!hold) begin
          exp_freq  = (cnt > MC) ? MC : cnt;
          exp_over  = (cnt > MC) ? 1 : 0;
          exp_valid = 1;
        end
        cnt = 0;
      end
    end
    #1;
    chk("valid", 32'(valid), exp_valid);
    chk("freq",  32'(freq),  exp_freq);
    chk("over",  32'(over),  exp_over);
    if (term_last) begin
      if (exp_valid == 1) begin
        if (last_valid >= 0) chk("valid_spacing", 32'(n - last_valid), GC);
        last_valid = n;
      end else begin
        last_valid = -1;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_to_terminal();
    bit done;
    done = 0;
    repeat (GC + SS + 2) begin
      if (!done) begin
        step();
        done = term_last;
      end
    end
  endtask

  task automatic release_reset();
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset with sig_in held high
    mode   = 0;
    level  = 1;
    sig_in = 1'b1;
    rand_hold = 0;
    period = 10;
    t_step = 0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("reset_freq",  32'(freq),  0);
    chk("reset_over",  32'(over),  0);
    chk("reset_valid", 32'(valid), 0);
    @(negedge clk);
    @(negedge clk);
    release_reset();

    // First window: no edges, first valid 103 cycles after release
    run_to_terminal();
    chk("first_valid", 32'(valid), 1);
    chk("first_freq",  32'(freq),  0);

    // Period-10 square wave
    mode = 1; period = 10;
    repeat (3) run_to_terminal();
    chk("sq10_freq", 32'(freq), 10);
    chk("sq10_over", 32'(over), 0);

    // Period 2 -> 50 edges, saturates
    period = 2;
    repeat (2) run_to_terminal();
    chk("sat_freq", 32'(freq), MC);
    chk("sat_over", 32'(over), 1);

    // Back to period 10
    period = 10;
    repeat (2) run_to_terminal();
    chk("unsat_freq", 32'(freq), 10);
    chk("unsat_over", 32'(over), 0);

    // Single rising edge reaching the counter in the terminal cycle
    mode = 0; level = 0;
    run_to_terminal();
    mode = 3; t_step = n + GC - SS;
    run_to_terminal();
    chk("single_edge_freq", 32'(freq), 1);
    run_to_terminal();
    chk("after_edge_freq", 32'(freq), 0);

    // hold across one terminal cycle
    mode = 1; period = 10;
    repeat (2) run_to_terminal();
    hold = 1'b1;
    run_to_terminal();
    chk("hold_valid", 32'(valid), 0);
    chk("hold_freq",  32'(freq),  10);
    hold = 1'b0;
    period = 5;
    run_to_terminal();
    chk("p5_valid", 32'(valid), 1);
    chk("p5_freq",  32'(freq),  20);
    chk("p5_over",  32'(over),  0);

    // Random sig_in and random hold
    mode = 2; rand_hold = 1;
    repeat (5) run_to_terminal();
    rand_hold = 0; hold = 1'b0;

    // Reset mid-window at timer 50
    mode = 1; period = 10;
    repeat (2) run_to_terminal();
    repeat (GC) begin
      if (((n - (SS + 2)) % GC) != 50) step();
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_freq",  32'(freq),  0);
    chk("midrst_over",  32'(over),  0);
    chk("midrst_valid", 32'(valid), 0);
    @(negedge clk);
    @(negedge clk);
    release_reset();
    run_to_terminal();
    chk("post_rst_valid", 32'(valid), 1);
    chk("post_rst_freq",  32'(freq),  10);
    chk("post_rst_n",     32'(n),     GC + SS + 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/freq_gate_counter.md
Name: freq_gate_counter

Overview:
- Measurement front end of the frequency counter; sits directly upstream of the binary-to-BCD converter and drives its 16-bit freq input.
- Synchronises the external signal, counts its rising edges over a fixed gate window of GATE_CYCLES clocks, and latches the saturated count once per window.
- Raises an over-range flag when the count exceeds the 4-digit display limit.

Parameters:
- GATE_CYCLES, 100000000: gate window length in clk cycles (1 s at 100 MHz).
- MAX_COUNT, 9999: saturation ceiling for the latched count, set by the 4-digit BCD display range.
- SYNC_STAGES, 2: flip-flops in the sig_in synchroniser chain (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sig_in  input  1  asynchronous signal under measurement.
- hold  input  1  1 = freeze freq/over at their current values; counting continues.
- freq  output  16  latched edge count of the last completed window, 0..MAX_COUNT.
- over  output  1  1 = last latched window counted more than MAX_COUNT edges.
- valid  output  1  one-cycle pulse when freq/over have just been updated.

Behaviour:
- Reset (rst_n=0, asynchronous): sync chain=0, prev=0, gate timer=0, edge_cnt=0, freq=0, over=0, valid=0, state=FLUSH.
- Synchroniser: SYNC_STAGES-FF chain on sig_in; s = last stage; prev = s delayed one clk.
- Edge detect: edge = s & ~prev, computed combinationally; counted only in GATE.
- FSM:
  - FLUSH: lasts SYNC_STAGES+1 cycles after reset release. Sync chain and prev run; edges ignored; timer and edge_cnt held at 0. Then go to GATE. Prevents a false edge when sig_in is high at reset release.
  - GATE: timer counts 0..GATE_CYCLES-1. Each cycle with edge=1 increments edge_cnt.
- edge_cnt is wide enough for GATE_CYCLES/2 edges and never wraps within a window.
- Terminal cycle (GATE, timer=GATE_CYCLES-1):
  - total = edge_cnt + edge; an edge in the terminal cycle belongs to the closing window.
  - On the closing clk edge: timer<=0, edge_cnt<=0; the next window starts with no dead cycles.
  - If hold=0 on the same edge: freq<=min(total, MAX_COUNT), over<=(total>MAX_COUNT), valid<=1.
  - If hold=1: freq, over and valid are unchanged (valid stays 0) and the window result is discarded.
- valid is high for exactly one cycle per window with hold=0, otherwise 0.
- Latency: freq/valid update on the first clk edge after the window's last sampled cycle. The total delay from sig_in pin to counted edge is SYNC_STAGES+1 clks.
- First result: the first valid pulse occurs SYNC_STAGES+1+GATE_CYCLES cycles after reset release.
- hold takes effect only at the terminal cycle; toggling it mid-window has no other effect.
- Reset mid-window: the partial count is discarded, outputs return to 0, and the FSM re-enters FLUSH.
- sig_in faster than clk/2 is undercounted; this is not flagged and is outside the spec.
- freq upper bits above MAX_COUNT width are always 0.

Test Plan (GATE_CYCLES=100, SYNC_STAGES=2 unless stated):
- Reset release, sig_in held 1 -> no edges counted; first valid at cycle 103 with freq=0, over=0.
- sig_in square wave, period 10 clk -> every window valid pulses with freq=10, over=0; valid pulses exactly 100 cycles apart.
- MAX_COUNT=20, sig_in period 2 clk (50 edges/window) -> freq=20, over=1; then period 10 clk -> next window freq=10, over=0.
- Single rising edge timed to reach s in the terminal cycle -> freq=1 for that window; following window freq=0.
- Period-10 wave, hold=1 across one terminal cycle -> no valid pulse, freq remains 10; then change to period 5 with hold=0 -> next window freq=20.
- rst_n pulsed low at timer=50 -> freq=0, over=0, valid=0 immediately; next valid 103 cycles after release with a full-window count.
